// File: rtl/div_pkg.sv
// Shared definitions for the sequential divide controller: operand width,
// the divide-by-zero quotient pattern and the controller state encoding.
package div_pkg;

    // Default operand / result width of the shared divide unit.
    localparam int DIV_WIDTH = 32;

    // Quotient reported when the divisor is zero (all ones).
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = {DIV_WIDTH{1'b1}};

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_seq_ctrl_div_step.sv
// One restoring shift-subtract step: shift {rem, quo} left by one, try to
// subtract the divisor magnitude from the widened partial remainder, keep
// the difference and set the quotient LSB when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dmag_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh_s;
    logic [WIDTH:0] trial_s;

    // Trial subtraction at WIDTH+1 bits; the top bit is the borrow/sign.
    always_comb begin
        rem_sh_s = {rem_i, quo_i[WIDTH-1]};
        trial_s  = rem_sh_s - {1'b0, dmag_i};
        rem_o    = rem_sh_s[WIDTH-1:0];
        quo_o    = {quo_i[WIDTH-2:0], 1'b0};
        if (trial_s[WIDTH] == 1'b0) begin
            rem_o = trial_s[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_sh_s[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle sequencer for the shared DIV/DIVU unit. Operands are reduced
// to magnitudes at start, a restoring divider produces one quotient bit per
// cycle, and a final cycle restores the signs. A zero divisor is answered
// immediately from IDLE without ever raising busy.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Two's-complement negate when en is set.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic en);
        logic [WIDTH-1:0] r;
        if (en) begin
            r = (~v) + WIDTH'(1'b1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sgn_q;
    logic             neg_a_q;
    logic             neg_b_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dmag_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_out_q;
    logic [WIDTH-1:0] rem_out_q;
    logic             dz_q;

    logic             divisor_zero_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_mag_d;
    logic [WIDTH-1:0] b_mag_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] quo_fix_d;
    logic [WIDTH-1:0] rem_fix_d;

    // Zero detect on the raw divisor; short-circuits the whole operation.
    assign divisor_zero_s = ~|divisor;

    // Operand magnitudes at start and sign restoration in the final cycle.
    always_comb begin
        a_neg_s   = is_signed & dividend[WIDTH-1];
        b_neg_s   = is_signed & divisor[WIDTH-1];
        a_mag_d   = cond_neg(dividend, a_neg_s);
        b_mag_d   = cond_neg(divisor, b_neg_s);
        quo_fix_d = cond_neg(quo_q, sgn_q & (neg_a_q ^ neg_b_q));
        rem_fix_d = cond_neg(rem_q, sgn_q & neg_a_q);
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dmag_i (dmag_q),
        .rem_o  (rem_d),
        .quo_o  (quo_d)
    );

    // Controller FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            sgn_q      <= 1'b0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            rem_q      <= {WIDTH{1'b0}};
            quo_q      <= {WIDTH{1'b0}};
            dmag_q     <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quot_out_q <= {WIDTH{1'b0}};
            rem_out_q  <= {WIDTH{1'b0}};
            dz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        if (divisor_zero_s) begin
                            // Answer at once; the replicated bit keeps the
                            // all-ones pattern correct for any WIDTH.
                            quot_out_q <= {WIDTH{DIV_ZERO_QUOT[0]}};
                            rem_out_q  <= dividend;
                            dz_q       <= 1'b1;
                            done_q     <= 1'b1;
                        end else begin
                            sgn_q   <= is_signed;
                            neg_a_q <= a_neg_s;
                            neg_b_q <= b_neg_s;
                            quo_q   <= a_mag_d;
                            dmag_q  <= b_mag_d;
                            rem_q   <= {WIDTH{1'b0}};
                            cnt_q   <= CNT_W'(WIDTH - 1);
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1'b1);
                    end
                end
                FIX: begin
                    quot_out_q <= quo_fix_d;
                    rem_out_q  <= rem_fix_d;
                    dz_q       <= 1'b0;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_out_q;
    assign remainder = rem_out_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int n_tests = 0;
    int n_fail  = 0;

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic, signed done in 64 bits (truncating division,
    // remainder takes the dividend's sign), zero divisor answered directly.
    function automatic void ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dz);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endfunction

    // Called at a negedge; presents a request across exactly one rising edge.
    task automatic issue(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    // Edges counted including the start edge; returns at the done negedge.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && edges < 100) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            edges++;
        end
        if (done !== 1'b1) check_eq("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_op(input string tag, input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        int           edges;
        int           bc;
        ref_div(sgn, a, b, eq, er, edz);
        issue(sgn, a, b);
        wait_done(edges, bc);
        check_eq({tag, "_quot"}, quotient, eq);
        check_eq({tag, "_rem"}, remainder, er);
        check_eq({tag, "_dz"}, div_zero, edz);
        check_eq({tag, "_lat"}, edges, (b == 32'd0) ? 1 : W + 2);
        check_eq({tag, "_busy"}, bc, (b == 32'd0) ? 0 : W + 1);
    endtask

    task automatic check_pulse_end(input string tag, input logic [W-1:0] eq);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, done, 1'b0);
        repeat (3) @(negedge clk);
        check_eq({tag, "_held"}, quotient, eq);
    endtask

    initial begin
        int edges;
        int bc;
        int done_seen;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_quot", quotient, 32'd0);
        check_eq("rst_rem", remainder, 32'd0);
        check_eq("rst_dz", div_zero, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        do_op("u100_7", 1'b0, 32'd100, 32'd7);
        check_pulse_end("u100_7", 32'd14);
        do_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        do_op("dz", 1'b0, 32'h0000_1234, 32'd0);
        check_pulse_end("dz", 32'hFFFF_FFFF);
        do_op("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);

        // Start during RUN must be ignored; then a start in the done cycle is taken.
        issue(1'b0, 32'd50, 32'd5);
        fork
            begin
                repeat (5) @(negedge clk);
                start     = 1'b1;
                is_signed = 1'b0;
                dividend  = 32'd9;
                divisor   = 32'd3;
                @(negedge clk);
                start = 1'b0;
            end
        join_none
        wait_done(edges, bc);
        check_eq("ign_quot", quotient, 32'd10);
        check_eq("ign_rem", remainder, 32'd0);
        check_eq("ign_lat", edges, W + 2);
        do_op("b2b", 1'b0, 32'd9, 32'd3);

        // Reset mid-operation at RUN step 10: everything clears, no done later.
        issue(1'b0, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_done", done, 1'b0);
        check_eq("mid_rst_quot", quotient, 32'd0);
        check_eq("mid_rst_rem", remainder, 32'd0);
        check_eq("mid_rst_dz", div_zero, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check_eq("mid_rst_quiet", done_seen, 0);
        do_op("post_rst", 1'b0, 32'd100, 32'd7);

        // Randomised operations, including the corner patterns.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            bit           sgn;
            int           mode;
            sgn  = 1'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 5));
            a    = $urandom;
            b    = $urandom;
            case (mode)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 1000)); b = 32'($urandom_range(1, 20)); end
                3: b = 32'($urandom_range(1, 300)) ^ {32{b[31]}};
                default: ;
            endcase
            do_op("rand", sgn, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for the CPU's shared 32-bit divide unit (MIPS DIV/DIVU).
- Runs a restoring shift-subtract divider one bit per cycle, then applies sign correction.
- Provides a start/busy/done handshake to the pipeline stall logic.
- Detects divide-by-zero with a reduction-NOR zero detector on the divisor and short-circuits the operation.

Parameters:
WIDTH, 32, operand and result width in bits.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a new divide; sampled only in IDLE.
is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
dividend  input  WIDTH  numerator; sampled with start.
divisor  input  WIDTH  denominator; sampled with start.
busy  output  1  operation in progress (RUN or FIX).
done  output  1  one-cycle pulse: results valid.
quotient  output  WIDTH  LO result; held until the next completion.
remainder  output  WIDTH  HI result; held until the next completion.
div_zero  output  1  last completed op had divisor == 0; held until the next completion.

Behaviour:
- Reset (async, any state):
  - state = IDLE; step counter = 0.
  - busy, done, div_zero = 0; quotient, remainder = 0.
  - An operation in flight is abandoned with no done.
- States:
  - IDLE, RUN, FIX. Encoded in the shared package.
- IDLE, start = 0:
  - Hold all result registers; done = 0 from the second IDLE cycle on.
- IDLE, start = 1, divisor == 0 (edge E0):
  - quotient = all-ones, remainder = dividend as given, div_zero = 1, done = 1 for one cycle.
  - Stay in IDLE; busy never asserts.
- IDLE, start = 1, divisor != 0 (edge E0):
  - Latch is_signed and operand signs.
  - Latch magnitudes: two's-complement negate if signed and MSB set; unsigned WIDTH-bit, so 2^(WIDTH-1) is representable.
  - Partial remainder = 0; counter = WIDTH-1; busy = 1; state -> RUN.
- RUN (edges E1..E_WIDTH): one restoring step per edge.
  - {rem, quo} shifted left by 1.
  - trial = rem_shifted - divisor_mag, computed at WIDTH+1 bits.
  - If the trial is non-negative: rem = trial and the quotient LSB = 1; otherwise the quotient LSB = 0.
  - Counter decrements. When counter == 0 at the edge, state -> FIX.
- FIX (edge E_WIDTH+1):
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend was negative.
  - Results are registered to the outputs; div_zero = 0; done = 1; busy = 0; state -> IDLE.
- Latency:
  - done is high in the cycle after edge E_(WIDTH+1), i.e. 33 edges after the start edge for WIDTH = 32.
  - Divide-by-zero: done after 1 edge.
- start while busy: ignored, with no effect on the operation or the operands.
- start in the cycle done is high: accepted (state is IDLE); back-to-back issue is legal.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0, no flag.
- Outputs are registered only; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package div_pkg holds:
  - state enum (IDLE, RUN, FIX);
  - WIDTH default;
  - DIV_ZERO_QUOT constant (all-ones).
- One natural sub-module: div_step, the combinational single restoring step.
  - Inputs: rem, quo, divisor_mag.
  - Outputs: next rem, next quo.
  - Instantiated once; the divisor zero check is a reduction-NOR inside div_seq_ctrl.

Test Plan:
- Unsigned 100 / 7, is_signed = 0 -> busy high for 33 cycles; done pulses exactly 33 edges after start; quotient = 14, remainder = 2, div_zero = 0.
- Signed 0xFFFFFFF9 (-7) / 2 -> quotient = 0xFFFFFFFD (-3), remainder = 0xFFFFFFFF (-1).
- Divide by zero: dividend 0x00001234, divisor 0 -> done one edge after start; busy never high; quotient = 0xFFFFFFFF, remainder = 0x00001234, div_zero = 1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient = 0x80000000, remainder = 0. Unsigned 0xFFFFFFFF / 1 -> quotient = 0xFFFFFFFF, remainder = 0.
- Start 50 / 5; pulse start with 9 / 3 at RUN cycle 5 -> ignored, result is quotient = 10, remainder = 0. Then start 9 / 3 in the done cycle -> accepted, quotient = 3 after 33 more edges.
- Assert rst mid-cycle at RUN step 10 -> busy, done, quotient, remainder, div_zero = 0 immediately, with no done later. A subsequent 100 / 7 completes normally.
